// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage built on a two-entry skid buffer.
// The main register drives the outputs. The skid register catches the one
// entry that arrives while the consumer stalls, so in_ready can stay a
// registered signal. It has no combinational path from out_ready.
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | main invalid, skid invalid
// ONE   | main valid (drives outputs), skid invalid
// FULL  | main and skid both valid, in_ready low
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_data, main_data_nxt;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_nxt;
    logic [DATA_W-1:0] skid_data, skid_data_nxt;
    logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_nxt;
    logic              accept;
    logic              fire;

    // Skid occupancy is encoded in the state. rst is the only
    // combinational term, so in_ready stays low while reset is held.
    assign in_ready  = (state != ST_FULL) && !rst;
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;

    assign accept = in_valid && in_ready;
    assign fire   = out_valid && out_ready;

    // State, main and skid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            state     <= state_nxt;
            main_data <= main_data_nxt;
            main_ctrl <= main_ctrl_nxt;
            skid_data <= skid_data_nxt;
            skid_ctrl <= skid_ctrl_nxt;
        end
    end

    // Next-state and datapath steering. Flush overrides accept and fire.
    // A handshake on the flush cycle is discarded.
    always_comb begin
        state_nxt     = state;
        main_data_nxt = main_data;
        main_ctrl_nxt = main_ctrl;
        skid_data_nxt = skid_data;
        skid_ctrl_nxt = skid_ctrl;
        if (flush) begin
            // out_data holds its value. Control bits are squashed.
            state_nxt     = ST_EMPTY;
            main_ctrl_nxt = '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt     = ST_ONE;
                        main_data_nxt = in_data;
                        main_ctrl_nxt = in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (accept && fire) begin
                        main_data_nxt = in_data;
                        main_ctrl_nxt = in_ctrl;
                    end else if (accept) begin
                        state_nxt     = ST_FULL;
                        skid_data_nxt = in_data;
                        skid_ctrl_nxt = in_ctrl;
                    end else if (fire) begin
                        state_nxt     = ST_EMPTY;
                        main_ctrl_nxt = '0;
                    end
                end
                ST_FULL: begin
                    if (fire) begin
                        state_nxt     = ST_ONE;
                        main_data_nxt = skid_data;
                        main_ctrl_nxt = skid_ctrl;
                    end
                end
                default: begin
                    state_nxt     = ST_EMPTY;
                    main_ctrl_nxt = '0;
                end
            endcase
        end
    end

    // Saturating stall counter. Only reset clears it. Flush does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register for the RISC-V core. It replaces the fixed EX/MEM-style latch with a valid/ready handshake stage built on a two-entry skid buffer, so it can sit between any two pipeline stages. It supports back-pressure, a synchronous flush that inserts bubbles, control-bit squashing on invalid slots, and a saturating stall counter for performance monitoring. Throughput is one transfer per cycle with a registered `in_ready`; there is no combinational ready path from `out_ready` to `in_ready`.

## Interface
- `DATA_W`, default 32: payload width (PC, ALU result, rs2 data, rd packed by the instantiating stage).
- `CTRL_W`, default 4: control-bit width (reg_write, mem_read, mem_write, mem_to_reg, ...). Forced to zero whenever its slot is invalid.
- `CNT_W`, default 16: stall counter width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `flush`  in  1: synchronous squash of all held entries.
- `in_valid`  in  1: upstream offers an entry.
- `in_ready`  out  1: the stage accepts an entry this cycle.
- `in_data`  in  DATA_W: upstream payload.
- `in_ctrl`  in  CTRL_W: upstream control bits.
- `out_valid`  out  1: `out_data`/`out_ctrl` hold a valid entry.
- `out_ready`  in  1: downstream consumes the entry this cycle.
- `out_data`  out  DATA_W: output payload.
- `out_ctrl`  out  CTRL_W: output control bits. Zero when `out_valid`=0.
- `stall_cnt`  out  CNT_W: saturating count of cycles with `out_valid`=1 and `out_ready`=0.

## Operation
- Storage is a main register (drives the outputs) and a skid register, each with a valid bit.
- `in_ready` = NOT `skid_valid` AND NOT `rst`.
- Accept = `in_valid` AND `in_ready`. Fire = `out_valid` AND `out_ready`.
- States and transitions:
  - EMPTY (main invalid, skid invalid):
    - accept → ONE, main ← in.
  - ONE (main valid, skid invalid):
    - accept and fire → ONE, main ← in.
    - accept, no fire → FULL, skid ← in.
    - fire, no accept → EMPTY.
    - neither → hold.
  - FULL (both valid), `in_ready`=0:
    - fire → ONE, main ← skid, skid invalid.
    - no fire → hold.
- Ordering is strict FIFO. An entry is never duplicated or dropped, except by flush.
- Flush (priority below `rst`, above everything else):
  - Next state EMPTY, both valids cleared, `out_ctrl` ← 0, `out_data` holds.
  - An entry handshaken on the flush cycle is discarded; upstream is flushed by the same hazard unit.
- Control squash: any transition to main-invalid also loads `out_ctrl` ← 0.
- `stall_cnt`:
  - Increments by 1 each cycle with `out_valid`=1 and `out_ready`=0, and saturates at 2^CNT_W−1.
  - Cleared only by `rst`; unaffected by `flush`.
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_ctrl`=0, `stall_cnt`=0, skid contents 0.
  - `in_ready`=0 while `rst`=1, and 1 on the first cycle after `rst` deasserts.

## Timing
- Latency from EMPTY: an entry accepted at edge N appears with `out_valid`=1 after edge N, i.e. one cycle.
- Sustained throughput is 1 entry/cycle while `out_ready`=1.
- `in_ready` is a pure register output: no combinational path from `out_ready` or `in_valid`.
- `out_valid`, `out_data` and `out_ctrl` are registered, with no combinational input-to-output path.
- One stall cycle with `in_valid` held raises `in_ready` low one cycle later (FULL). Once `out_ready` returns, `in_ready` recovers one cycle after the fire.
- Simultaneous events:
  - `rst` beats `flush`, and `flush` beats accept and fire.
  - In ONE, accept and fire on the same cycle replaces main without a bubble.
- Counter wrap is prohibited; it saturates at the maximum value.

## Test plan
- Reset: hold `rst` 2 cycles with `in_valid`=1 and `in_data`=0xDEADBEEF → `in_ready`=0, `out_valid`=0, `out_ctrl`=0, `stall_cnt`=0. On the first cycle after release, `in_ready`=1.
- Streaming: 8 back-to-back entries 0x1..0x8 with `out_ready`=1 → outputs 0x1..0x8 on consecutive cycles, one cycle delayed, `in_ready` stays 1, `stall_cnt`=0.
- Back-pressure: send 0xA, 0xB, 0xC with `out_ready`=0 from cycle 1 → state FULL, `in_ready`=0, 0xC still offered. Raise `out_ready` after 3 stall cycles → out order 0xA, 0xB, 0xC, no loss, `stall_cnt`=3.
- Flush in FULL (0x10 in main, 0x11 in skid, `in_ctrl`=0xF) → next cycle `out_valid`=0, `out_ctrl`=0, `in_ready`=1. A subsequent 0x12 emerges next, never 0x11.
- Flush on the same cycle as an accept of 0x20 → 0x20 never appears at the output.
- Saturation with CNT_W=4: hold `out_valid`=1 and `out_ready`=0 for 20 cycles → `stall_cnt` reaches 15 and stays at 15. A mid-run `flush` leaves it unchanged; `rst` clears it to 0.
